// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle main FSM (master) and the MIPS32 datapath/memory (slave).
// mem_read/mem_write are requests held high until the cycle mem_ready=1 completes them; no transfer happens without both.
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] aluop;
    logic       illegal;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               pc_source, aluop, illegal
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               pc_source, aluop, illegal
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS32 main control FSM: fetch/decode/execute/memory/writeback sequencing,
// datapath enables, mux selects and the 2-bit aluop fed to the ALU control decoder.
module mips_multicycle_control #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic                           clk,
    input  logic                           rst,
    mips_multicycle_control_if.master      ctrl,
    output logic [3:0]                     state
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
        BRANCH = 4'd8,  JUMP   = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_t state_q, state_d;

    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_source, aluop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= state_t'(RESET_STATE);
        else      state_q <= state_d;
    end

    always_comb begin
        state_d       = FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        aluop         = 2'b00;
        illegal       = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (ctrl.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else begin
                    state_d  = FETCH;
                end
            end
            DECODE: begin
                // ALU precomputes PC + (signext << 2) so BRANCH finds the target in ALUOut.
                alu_src_b = 2'b11;
                case (ctrl.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDIEX;
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (ctrl.opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = ctrl.mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                state_d   = ctrl.mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                aluop     = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                aluop         = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        // Reset overrides the decode so no strobe (and no pending write) survives rst falling.
        if (!rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b01;
            pc_source     = 2'b00;
            aluop         = 2'b00;
            illegal       = 1'b0;
        end
    end

    assign ctrl.pc_write      = pc_write;
    assign ctrl.pc_write_cond = pc_write_cond;
    assign ctrl.iord          = iord;
    assign ctrl.mem_read      = mem_read;
    assign ctrl.mem_write     = mem_write;
    assign ctrl.ir_write      = ir_write;
    assign ctrl.mem_to_reg    = mem_to_reg;
    assign ctrl.reg_dst       = reg_dst;
    assign ctrl.reg_write     = reg_write;
    assign ctrl.alu_src_a     = alu_src_a;
    assign ctrl.alu_src_b     = alu_src_b;
    assign ctrl.pc_source     = pc_source;
    assign ctrl.aluop         = aluop;
    assign ctrl.illegal       = illegal;
    assign state              = state_q;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: instructions are expanded into per-cycle expected
// control words by a phase-level model, then replayed against the DUT cycle by cycle.
module tb_mips_multicycle_control;
    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, asa;
        logic [1:0] asb, pcs, aluop;
        logic       ill;
    } ov_t;

    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4, K_ADDI = 5, K_ILL = 6;

    logic       clk;
    logic       rst;
    logic [3:0] state;
    int         n_checks;
    int         n_errors;
    int         cyc;

    logic [20:0] exp_q[$];
    logic [5:0]  op_q[$];
    logic        mr_q[$];

    mips_multicycle_control_if bus ();

    mips_multicycle_control dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus.master),
        .state(state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ov_t observe();
        ov_t o;
        o.st    = state;
        o.pcw   = bus.pc_write;
        o.pcwc  = bus.pc_write_cond;
        o.iord  = bus.iord;
        o.mrd   = bus.mem_read;
        o.mwr   = bus.mem_write;
        o.irw   = bus.ir_write;
        o.m2r   = bus.mem_to_reg;
        o.rdst  = bus.reg_dst;
        o.rwr   = bus.reg_write;
        o.asa   = bus.alu_src_a;
        o.asb   = bus.alu_src_b;
        o.pcs   = bus.pc_source;
        o.aluop = bus.aluop;
        o.ill   = bus.illegal;
        return o;
    endfunction

    function automatic ov_t base(input int st);
        ov_t e;
        e    = '0;
        e.st = 4'(st);
        return e;
    endfunction

    function automatic ov_t reset_word();
        ov_t e;
        e     = base(0);
        e.asb = 2'b01;
        return e;
    endfunction

    function automatic logic [5:0] kind_op(input int kind);
        logic [5:0] op;
        case (kind)
            K_R:     op = 6'b000000;
            K_LW:    op = 6'b100011;
            K_SW:    op = 6'b101011;
            K_BEQ:   op = 6'b000100;
            K_J:     op = 6'b000010;
            K_ADDI:  op = 6'b001000;
            default: begin
                do op = 6'($urandom_range(0, 63));
                while (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000});
            end
        endcase
        return op;
    endfunction

    // Driver: one queued cycle of stimulus plus the control word it must produce
    task automatic push(input logic [5:0] op, input logic mr, input ov_t e);
        op_q.push_back(op);
        mr_q.push_back(mr);
        exp_q.push_back(e);
    endtask

    function automatic logic [5:0] junk();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Model: a memory access phase is mw not-ready cycles followed by one completing cycle.
    task automatic push_mem(input int st, input logic rd, input int mw, input bit stop);
        ov_t e;
        e      = base(st);
        e.iord = 1'b1;
        e.mrd  = rd;
        e.mwr  = !rd;
        for (int i = 0; i < mw; i++) push(junk(), 1'b0, e);
        if (!stop) push(junk(), 1'b1, e);
    endtask

    task automatic plan_instr(input int kind, input logic [5:0] op, input int fw, input int mw,
                              input bit stop);
        ov_t e;
        e     = base(0);
        e.mrd = 1'b1;
        e.asb = 2'b01;
        for (int i = 0; i < fw; i++) push(junk(), 1'b0, e);
        e.irw = 1'b1;
        e.pcw = 1'b1;
        push(junk(), 1'b1, e);

        e     = base(1);
        e.asb = 2'b11;
        e.ill = (kind == K_ILL);
        push(op, rnd_bit(), e);

        case (kind)
            K_LW, K_SW: begin
                e     = base(2);
                e.asa = 1'b1;
                e.asb = 2'b10;
                push(op, rnd_bit(), e);
                if (kind == K_LW) begin
                    push_mem(3, 1'b1, mw, stop);
                    e     = base(4);
                    e.rwr = 1'b1;
                    e.m2r = 1'b1;
                    push(junk(), rnd_bit(), e);
                end else begin
                    push_mem(5, 1'b0, mw, stop);
                end
            end
            K_R: begin
                e       = base(6);
                e.asa   = 1'b1;
                e.aluop = 2'b10;
                push(junk(), rnd_bit(), e);
                e      = base(7);
                e.rwr  = 1'b1;
                e.rdst = 1'b1;
                push(junk(), rnd_bit(), e);
            end
            K_BEQ: begin
                e       = base(8);
                e.asa   = 1'b1;
                e.aluop = 2'b01;
                e.pcwc  = 1'b1;
                e.pcs   = 2'b01;
                push(junk(), rnd_bit(), e);
            end
            K_J: begin
                e     = base(9);
                e.pcw = 1'b1;
                e.pcs = 2'b10;
                push(junk(), rnd_bit(), e);
            end
            K_ADDI: begin
                e     = base(10);
                e.asa = 1'b1;
                e.asb = 2'b10;
                push(junk(), rnd_bit(), e);
                e     = base(11);
                e.rwr = 1'b1;
                push(junk(), rnd_bit(), e);
            end
            default: ;
        endcase
    endtask

    // Scoreboard: replay each queued cycle and compare the whole control word
    task automatic drain();
        logic [20:0] e;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            bus.opcode    = op_q.pop_front();
            bus.mem_ready = mr_q.pop_front();
            e             = exp_q.pop_front();
            #1;
            check($sformatf("cyc%0d_st%0d", cyc, e[20:17]), 32'(observe()), 32'(e));
            cyc++;
        end
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        cyc           = 0;
        rst           = 1'b0;
        bus.mem_ready = 1'b1;
        bus.opcode    = 6'b000000;

        repeat (2) @(posedge clk);
        #1;
        check("reset_word", 32'(observe()), 32'(reset_word()));
        @(negedge clk);
        #1;
        check("reset_word_mid", 32'(observe()), 32'(reset_word()));
        @(posedge clk);
        #1;
        rst = 1'b1;

        plan_instr(K_R,   kind_op(K_R),   0, 0, 1'b0);
        plan_instr(K_LW,  kind_op(K_LW),  0, 2, 1'b0);
        plan_instr(K_BEQ, kind_op(K_BEQ), 0, 0, 1'b0);
        plan_instr(K_J,   kind_op(K_J),   0, 0, 1'b0);
        plan_instr(K_ILL, 6'b111111,      0, 0, 1'b0);
        plan_instr(K_SW,  kind_op(K_SW),  1, 1, 1'b0);
        plan_instr(K_ADDI, kind_op(K_ADDI), 0, 0, 1'b0);
        drain();

        // sw stalled in MEMWR, then reset drops mem_write before any edge
        plan_instr(K_SW, kind_op(K_SW), 0, 1, 1'b1);
        drain();
        rst = 1'b0;
        #1;
        check("rst_mid_memwr", 32'(observe()), 32'(reset_word()));
        @(posedge clk);
        #1;
        check("rst_hold", 32'(observe()), 32'(reset_word()));
        rst = 1'b1;

        for (int n = 0; n < 150; n++) begin
            int kind;
            kind = $urandom_range(0, 6);
            plan_instr(kind, kind_op(kind), $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multicycle main control FSM for the MIPS32 core, i.e. the producer side of the 2-bit aluop interface that the ALU control decoder consumes.
- Sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- Drives datapath enables, mux selects and aluop.
- Stalls on a memory ready handshake.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- opcode  input  6  instr[31:26] from IR; sampled in DECODE.
- mem_ready  input  1  memory completes the current access this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if ALU zero.
- iord  output  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  IR load.
- mem_to_reg  output  1  write-back data select: 1=MDR.
- reg_dst  output  1  destination register select: 1=rd, 0=rt.
- reg_write  output  1  register file write.
- alu_src_a  output  1  ALU A select: 0=PC, 1=A reg.
- alu_src_b  output  2  ALU B select: 00=B, 01=4, 10=signext, 11=signext<<2.
- pc_source  output  2  PC source: 00=ALU, 01=ALUOut, 10=jump target.
- aluop  output  2  00=add, 01=sub, 10=R-format (decode funct).
- illegal  output  1  one-cycle pulse on an unsupported opcode.
- state  output  4  current state (debug).

Behaviour:
- State register changes only on rising clk; rst low forces state=FETCH immediately.
- While rst is low, all strobes (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, illegal) are 0. Selects take their FETCH values: iord=0, alu_src_a=0, alu_src_b=01, aluop=00, pc_source=00.
- After rst deasserts, FETCH begins on the next edge.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
- States and transitions:
  - FETCH(0):
    - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, aluop=00, pc_source=00.
    - ir_write and pc_write are asserted only when mem_ready=1.
    - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE(1):
    - Outputs: alu_src_a=0, alu_src_b=11, aluop=00 (branch target precompute).
    - Next state: lw/sw->MEMADR; R->EXEC; beq->BRANCH; j->JUMP; addi->ADDIEX.
    - Any other opcode -> FETCH, with illegal=1 during this DECODE cycle.
  - MEMADR(2): alu_src_a=1, alu_src_b=10, aluop=00. lw->MEMRD; sw->MEMWR.
  - MEMRD(3): mem_read=1, iord=1. Wait for mem_ready, then go to MEMWB.
  - MEMWB(4): reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
  - MEMWR(5): mem_write=1, iord=1. Wait for mem_ready, then go to FETCH.
  - EXEC(6): alu_src_a=1, alu_src_b=00, aluop=10. Next: ALUWB.
  - ALUWB(7): reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, aluop=01, pc_write_cond=1, pc_source=01. Next: FETCH.
  - JUMP(9): pc_write=1, pc_source=10. Next: FETCH.
  - ADDIEX(10): alu_src_a=1, alu_src_b=10, aluop=00. Next: ADDIWB.
  - ADDIWB(11): reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
  - Encodings 12-15: all strobes 0; next state FETCH (recovery).
- Defaults: any output not listed for a state is 0.
- Strobe outputs are combinational from state (plus mem_ready in FETCH, MEMRD, MEMWR). No registered output latency.
- Cycle counts with mem_ready constantly 1:
  - R, sw, addi: 4.
  - lw: 5.
  - beq, j: 3.
  - Illegal opcode: 2.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. mem_write and mem_read stay asserted throughout the wait.
- Reset asserted mid-instruction: state returns to FETCH asynchronously and all strobes drop in the same cycle. No partial write completes after reset assertion.
- opcode is only sampled in DECODE and MEMADR; changes in other states have no effect.

Test Plan:
- Reset: hold rst=0 with mem_ready=1 -> state=0, all strobes 0. Release rst -> the next cycle shows mem_read=1, ir_write=1, pc_write=1.
- R-type (opcode 000000), mem_ready=1 -> state sequence 0,1,6,7,0. aluop=10 in EXEC. reg_write=1 and reg_dst=1 only in ALUWB.
- lw (100011) with mem_ready=0 for 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4,0. mem_read=1 and iord=1 for all three MEMRD cycles. reg_write=1 and mem_to_reg=1 in MEMWB.
- beq (000100) then j (000010) -> BRANCH cycle: aluop=01, pc_write_cond=1, pc_source=01. JUMP cycle: pc_write=1, pc_source=10. Each instruction takes 3 cycles.
- Illegal opcode 111111 -> illegal=1 for exactly one cycle in DECODE, then FETCH; no reg_write or mem_write is ever asserted.
- sw (101011) with rst pulled low while in MEMWR and mem_ready=0 -> mem_write drops to 0 immediately; state=0 before the next clk edge.
